// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared defaults and the fetch-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          DEF_ADDR_W   = 64;
  localparam int          DEF_INSTR_W  = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;

  // Sequential fetch advances by one 32-bit instruction word.
  localparam int          PC_STEP      = 4;

  // One queue entry at the default widths: the fetched word and its PC.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_stage_if
// Description : Redirect, instruction-memory and decode-side handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_stage_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               redirect_br;
  logic [ADDR_W-1:0]  br_target;
  logic               redirect_reg;
  logic [ADDR_W-1:0]  reg_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc4;
  logic [CNT_W-1:0]   count;

  // Environment side: redirect source, instruction memory and decode.
  modport master (
    output redirect_br, br_target, redirect_reg, reg_target, imem_instr, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, out_pc4, count
  );

  // Fetch stage side.
  modport slave (
    input  redirect_br, br_target, redirect_reg, reg_target, imem_instr, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, out_pc4, count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Fetch queue of {instr, pc} entries with single-cycle flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic [INSTR_W-1:0]       push_instr,
  input  wire logic [ADDR_W-1:0]        push_pc,
  input  wire logic                     pop,
  input  wire logic                     flush,
  output logic      [INSTR_W-1:0]       head_instr,
  output logic      [ADDR_W-1:0]        head_pc,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  // Next-state for storage, pointers and occupancy; flush empties the queue.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: push_instr, pc: push_pc};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_instr = mem_q[rd_ptr_q].instr;
  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_stage
// Description : PC register, next-PC selection and a decoupling fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  fetch_buffer_stage_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;
  logic               redirect;
  logic               full;
  logic               pop;
  logic               push;

  assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

  // Handshake decode and next-PC select: register target beats branch target.
  always_comb begin
    redirect = bus.redirect_reg | bus.redirect_br;
    full     = (count == CNT_W'(DEPTH));
    pop      = (count != '0) & bus.out_ready;
    push     = ~redirect & (~full | pop);
    pc_d     = pc_q;
    if (bus.redirect_reg) begin
      pc_d = bus.reg_target;
    end else if (bus.redirect_br) begin
      pc_d = bus.br_target;
    end else if (push) begin
      pc_d = pc_plus4;
    end
  end

  // Program counter, loaded asynchronously with RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_instr (bus.imem_instr),
    .push_pc    (pc_q),
    .pop        (pop),
    .flush      (redirect),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = head_pc;
  assign bus.out_pc4   = head_pc + ADDR_W'(PC_STEP);
  assign bus.count     = count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer_stage
// Description : Directed table-driven bench for fetch_buffer_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer_stage;
  import fetch_pkg::*;

  localparam logic [63:0] HI_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_buffer_stage_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4)) b1 ();
  fetch_buffer_stage_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4)) b2 ();

  fetch_buffer_stage #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  fetch_buffer_stage #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(HI_RESET_PC)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: a distinct word per address.
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_5A5A;
  endfunction

  always_comb b1.imem_instr = imem_word(b1.imem_addr);
  always_comb b2.imem_instr = imem_word(b2.imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the full head entry (instr and PC) of dut1 against the model.
  task automatic check_head(input string tag, input logic [63:0] exp_pc);
    fetch_entry_t exp_e;
    exp_e.pc    = exp_pc;
    exp_e.instr = imem_word(exp_pc);
    check({tag, " out_pc"},    b1.out_pc,           exp_e.pc);
    check({tag, " out_pc4"},   b1.out_pc4,          exp_e.pc + 64'd4);
    check({tag, " out_instr"}, 64'(b1.out_instr),   64'(exp_e.instr));
  endtask

  typedef struct {
    logic        rdy;
    logic        br;
    logic [63:0] brt;
    logic        rg;
    logic [63:0] rgt;
    logic        ev;
    logic [63:0] epc;
    int          ecnt;
    logic [63:0] eaddr;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vt [NVEC];

  function automatic vec_t mk(input logic rdy, input logic br, input logic [63:0] brt,
                              input logic rg, input logic [63:0] rgt, input logic ev,
                              input logic [63:0] epc, input int ecnt, input logic [63:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.br = br; v.brt = brt; v.rg = rg; v.rgt = rgt;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    return v;
  endfunction

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Expected outputs describe the state visible before the row's inputs act.
    //          rdy  br   brt        rg   rgt          ev   epc      cnt  addr
    vt[0]  = mk(0,  0, 64'h0,     0, 64'h0,      0, 64'h0,    0, 64'h0);
    vt[1]  = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h0,    1, 64'h4);
    vt[2]  = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h0,    2, 64'h8);
    vt[3]  = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h0,    3, 64'hC);
    vt[4]  = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h0,    4, 64'h10);
    vt[5]  = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h0,    4, 64'h10);
    vt[6]  = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h0,    4, 64'h10);
    vt[7]  = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h4,    4, 64'h14);
    vt[8]  = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h8,    4, 64'h18);
    vt[9]  = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'hC,    4, 64'h1C);
    vt[10] = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h10,   4, 64'h20);
    vt[11] = mk(1,  1, 64'h80,    0, 64'h0,      1, 64'h14,   4, 64'h24);
    vt[12] = mk(0,  0, 64'h0,     0, 64'h0,      0, 64'h0,    0, 64'h80);
    vt[13] = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h80,   1, 64'h84);
    vt[14] = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h80,   2, 64'h88);
    vt[15] = mk(0,  1, 64'h100,   0, 64'h0,      1, 64'h80,   3, 64'h8C);
    vt[16] = mk(1,  0, 64'h0,     0, 64'h0,      0, 64'h0,    0, 64'h100);
    vt[17] = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h100,  1, 64'h104);
    vt[18] = mk(0,  0, 64'h0,     0, 64'h0,      1, 64'h104,  1, 64'h108);
    vt[19] = mk(1,  1, 64'h100,   1, 64'h200,    1, 64'h104,  2, 64'h10C);
    vt[20] = mk(1,  0, 64'h0,     0, 64'h0,      0, 64'h0,    0, 64'h200);
    vt[21] = mk(1,  0, 64'h0,     1, 64'h1233,   1, 64'h200,  1, 64'h204);
    vt[22] = mk(1,  0, 64'h0,     0, 64'h0,      0, 64'h0,    0, 64'h1233);
    vt[23] = mk(1,  0, 64'h0,     0, 64'h0,      1, 64'h1233, 1, 64'h1237);

    reset           = 1'b1;
    b1.out_ready    = 1'b0;
    b1.redirect_br  = 1'b0;
    b1.br_target    = '0;
    b1.redirect_reg = 1'b0;
    b1.reg_target   = '0;
    b2.out_ready    = 1'b1;
    b2.redirect_br  = 1'b0;
    b2.br_target    = '0;
    b2.redirect_reg = 1'b0;
    b2.reg_target   = '0;

    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(b1.out_valid), 64'd0);
    check("reset count",     64'(b1.count),     64'd0);
    check("reset imem_addr", b1.imem_addr,      64'h0);
    check("reset2 imem_addr", b2.imem_addr,     HI_RESET_PC);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      b1.out_ready    = vt[i].rdy;
      b1.redirect_br  = vt[i].br;
      b1.br_target    = vt[i].brt;
      b1.redirect_reg = vt[i].rg;
      b1.reg_target   = vt[i].rgt;
      #1;
      check($sformatf("v%0d out_valid", i), 64'(b1.out_valid), 64'(vt[i].ev));
      check($sformatf("v%0d count", i),     64'(b1.count),     64'(vt[i].ecnt));
      check($sformatf("v%0d imem_addr", i), b1.imem_addr,      vt[i].eaddr);
      if (vt[i].ev) check_head($sformatf("v%0d", i), vt[i].epc);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream, asserted between clock edges.
    b1.out_ready    = 1'b1;
    b1.redirect_br  = 1'b0;
    b1.redirect_reg = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async out_valid",  64'(b1.out_valid), 64'd0);
    check("async count",      64'(b1.count),     64'd0);
    check("async imem_addr",  b1.imem_addr,      64'h0);
    check("async2 out_valid", 64'(b2.out_valid), 64'd0);
    check("async2 imem_addr", b2.imem_addr,      HI_RESET_PC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First cycle after release: heads come from the reset PCs.
    @(negedge clk);
    check("rel out_valid", 64'(b1.out_valid), 64'd1);
    check_head("rel", 64'h0);
    check("rel imem_addr", b1.imem_addr, 64'h4);
    check("wrap out_pc",    b2.out_pc,    HI_RESET_PC);
    check("wrap out_pc4",   b2.out_pc4,   64'h0);
    check("wrap imem_addr", b2.imem_addr, 64'h0);

    // Second cycle: the wrapped PC has been fetched.
    @(negedge clk);
    check_head("rel2", 64'h4);
    check("wrap2 out_pc",    b2.out_pc,              64'h0);
    check("wrap2 out_instr", 64'(b2.out_instr),      64'(imem_word(64'h0)));
    check("wrap2 count",     64'(b2.count),          64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_buffer_stage.md
FETCH_BUFFER_STAGE -- requirements
Module: fetch_buffer_stage

Interface
REQ-001 Parameter ADDR_W, default 64, width of the PC and all address ports.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 redirect_br  input  1  PC-relative branch taken; load br_target.
REQ-008 br_target  input  ADDR_W  branch target address (PC + offset, computed upstream).
REQ-009 redirect_reg  input  1  register branch (BR); load reg_target.
REQ-010 reg_target  input  ADDR_W  register-supplied target address.
REQ-011 imem_addr  output  ADDR_W  instruction-memory address; equals the current PC.
REQ-012 imem_instr  input  INSTR_W  instruction at imem_addr, valid in the same cycle (combinational read).
REQ-013 out_valid  output  1  head queue entry is valid.
REQ-014 out_ready  input  1  decode accepts the head entry.
REQ-015 out_instr  output  INSTR_W  head entry instruction.
REQ-016 out_pc  output  ADDR_W  head entry PC.
REQ-017 out_pc4  output  ADDR_W  head entry PC + 4, modulo 2^ADDR_W.
REQ-018 count  output  $clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-019 Transfer: out_valid && out_ready in a cycle pops the head entry at that cycle's clock edge.
REQ-020 out_valid SHALL be 1 exactly when count != 0; out_instr/out_pc/out_pc4 are driven from the head entry and are don't-care while out_valid = 0.
REQ-021 Fetch: when no redirect is asserted and (count < DEPTH or a pop occurs), {imem_instr, PC} is pushed and PC <= PC + 4.
REQ-022 When full with no pop and no redirect, the fetch stalls: no push, PC holds, imem_addr holds.
REQ-023 Push and pop in the same cycle leave count unchanged and preserve FIFO order.
REQ-024 Redirect priority: redirect_reg overrides redirect_br; PC <= reg_target if redirect_reg, else br_target if redirect_br.
REQ-025 On redirect: no push; all entries left after any same-cycle pop are flushed, so count = 0 next cycle.
REQ-026 A pop coinciding with a redirect still counts as delivered to decode.
REQ-027 Latency: the PC presented on imem_addr in cycle N appears on out_pc no earlier than cycle N+1 (N+1 when the queue was empty).
REQ-028 PC arithmetic SHALL wrap modulo 2^ADDR_W; targets are loaded unmodified (no alignment forcing).
REQ-029 count SHALL never exceed DEPTH, and no pop occurs while count = 0.

Reset
REQ-030 reset asserted SHALL immediately set PC = RESET_PC, count = 0, queue pointers = 0, out_valid = 0, independent of clk.
REQ-031 Reset mid-operation discards all queue contents; the first fetch after deassertion is from RESET_PC.

Structure
REQ-032 The shared package fetch_pkg SHALL hold the default parameter constants and the queue-entry struct {instr, pc}.
REQ-033 The queue SHALL be one sub-module, fetch_fifo (parametrised DEPTH, flush input); PC register, next-PC selection and +4 adder live in the top.

Verification (DEPTH=4, RESET_PC=0 unless stated)
REQ-034 Release reset, out_ready=1 held -> out_valid rises 1 cycle after release; out_pc = 0x0, 0x4, 0x8, ... on consecutive cycles; out_pc4 = out_pc + 4.
REQ-035 out_ready=0 for 6 cycles, then 1 -> count saturates at 4, imem_addr holds 0x10; drain order out_pc 0x0, 0x4, 0x8, 0xC, then 0x10 follows.
REQ-036 count=3, pulse redirect_br with br_target=0x100 -> next cycle count=0, out_valid=0, imem_addr=0x100; the cycle after, out_pc=0x100.
REQ-037 redirect_br (0x100) and redirect_reg (0x200) in the same cycle, with a pop -> head popped, count=0 next cycle, imem_addr=0x200.
REQ-038 Full queue with out_ready=1 -> push and pop each cycle, count stays 4, out_pc strictly +4 per cycle.
REQ-039 RESET_PC=0xFFFF_FFFF_FFFF_FFFC -> first out_pc4 = 0x0 and the second fetch uses imem_addr = 0x0; asynchronous reset asserted mid-stream -> out_valid=0 and imem_addr=RESET_PC before the next clk edge.
